// File: rtl/am_query_sched.sv
// rtl/am_query_sched.sv - single-query-in-flight scheduler wrapping an associative-memory inference
//
// Purpose: accepts one encoded-HV query at a time, launches the AM, waits
// SEQ_CYCLE_COUNT compare cycles plus AM_RESULT_LAT drain cycles, samples the
// winning class, scores it against the ground-truth label and keeps saturating
// correct/total tallies. An end-of-dataset pulse follows the last query's result.
//
// Ports:
//   clk, nrst                  clock, synchronous active-low reset
//   en                         global enable; 0 freezes state and masks pulses
//   clr                        zero the tallies (IDLE only)
//   query_valid/query_ready    query handshake
//   query_label, query_last    ground-truth class and final-query flag
//   start_querying             one-cycle AM launch pulse
//   testing_dataset_finished   one-cycle pulse after the last result
//   class_inference            AM winning class
//   result_valid/_class/_correct  one-cycle result strobe with captured class and score
//   correct_count, total_count saturating tallies
//   busy, done                 not-IDLE flag, end-of-dataset strobe
module am_query_sched #(
  parameter int SEQ_CYCLE_COUNT = 10,
  parameter int AM_RESULT_LAT   = 2,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             clr,
  input  logic             query_valid,
  output logic             query_ready,
  input  logic [4:0]       query_label,
  input  logic             query_last,
  output logic             start_querying,
  output logic             testing_dataset_finished,
  input  logic [4:0]       class_inference,
  output logic             result_valid,
  output logic [4:0]       result_class,
  output logic             result_correct,
  output logic [CNT_W-1:0] correct_count,
  output logic [CNT_W-1:0] total_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_COMPARE, S_DRAIN, S_REPORT, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_cnt;
  logic [4:0]       r_label;
  logic             r_last;
  logic [4:0]       r_class;
  logic             r_ok;
  logic [CNT_W-1:0] r_correct;
  logic [CNT_W-1:0] r_total;

  logic w_hs;
  logic w_cnt_zero;
  logic w_sample;
  logic w_match;

  assign w_hs       = query_valid & query_ready;
  assign w_cnt_zero = (r_cnt == 32'd0);
  assign w_match    = (class_inference == r_label);

  // The result is captured on the edge leaving the last wait cycle: the final
  // DRAIN cycle, or the final COMPARE cycle when there is no drain latency.
  assign w_sample = en && w_cnt_zero &&
                    ((r_state == S_DRAIN) ||
                     ((r_state == S_COMPARE) && (AM_RESULT_LAT == 0)));

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_hs) w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_COMPARE;
      S_COMPARE: if (w_cnt_zero) w_next = (AM_RESULT_LAT == 0) ? S_REPORT : S_DRAIN;
      S_DRAIN:   if (w_cnt_zero) w_next = S_REPORT;
      S_REPORT:  w_next = r_last ? S_DONE : S_IDLE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Phase down-counter, query latches, result capture and tallies
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt     <= '0;
      r_label   <= '0;
      r_last    <= 1'b0;
      r_class   <= '0;
      r_ok      <= 1'b0;
      r_correct <= '0;
      r_total   <= '0;
    end else if (en) begin
      // Counter is loaded with (phase length - 1) on entry and the phase ends at zero.
      if (r_state == S_LAUNCH) begin
        r_cnt <= 32'(SEQ_CYCLE_COUNT - 1);
      end else if ((r_state == S_COMPARE) && w_cnt_zero) begin
        r_cnt <= (AM_RESULT_LAT > 0) ? 32'(AM_RESULT_LAT - 1) : 32'd0;
      end else if (((r_state == S_COMPARE) || (r_state == S_DRAIN)) && !w_cnt_zero) begin
        r_cnt <= r_cnt - 32'd1;
      end

      if (w_hs) begin
        r_label <= query_label;
        r_last  <= query_last;
      end

      if (w_sample) begin
        r_class <= class_inference;
        r_ok    <= w_match;
      end

      // clr is only meaningful in IDLE, where no sample can occur.
      if (clr && (r_state == S_IDLE)) begin
        r_correct <= '0;
        r_total   <= '0;
      end else if (w_sample) begin
        if (r_total != {CNT_W{1'b1}}) r_total <= r_total + 1'b1;
        if (w_match && (r_correct != {CNT_W{1'b1}})) r_correct <= r_correct + 1'b1;
      end
    end
  end

  // Output decode; every strobe is masked while en is low.
  always_comb begin
    query_ready              = 1'b0;
    start_querying           = 1'b0;
    result_valid             = 1'b0;
    testing_dataset_finished = 1'b0;
    done                     = 1'b0;
    busy                     = (r_state != S_IDLE);
    if (en) begin
      case (r_state)
        S_IDLE:   query_ready = 1'b1;
        S_LAUNCH: start_querying = 1'b1;
        S_REPORT: result_valid = 1'b1;
        S_DONE: begin
          testing_dataset_finished = 1'b1;
          done                     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result_class   = r_class;
  assign result_correct = r_ok;
  assign correct_count  = r_correct;
  assign total_count    = r_total;

endmodule

// File: tb/tb_am_query_sched.sv
// tb/tb_am_query_sched.sv - directed table-driven bench for am_query_sched
module tb_am_query_sched;

  localparam int SEQ = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        nrst, en, clr, query_valid, query_last;
  logic [4:0]  query_label, class_inference;
  logic        query_ready, start_querying, testing_dataset_finished;
  logic        result_valid, result_correct, busy, done;
  logic [4:0]  result_class;
  logic [15:0] correct_count, total_count;

  am_query_sched #(.SEQ_CYCLE_COUNT(SEQ), .AM_RESULT_LAT(LAT), .CNT_W(16)) dut_a (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr),
    .query_valid(query_valid), .query_ready(query_ready),
    .query_label(query_label), .query_last(query_last),
    .start_querying(start_querying), .testing_dataset_finished(testing_dataset_finished),
    .class_inference(class_inference),
    .result_valid(result_valid), .result_class(result_class), .result_correct(result_correct),
    .correct_count(correct_count), .total_count(total_count),
    .busy(busy), .done(done)
  );

  // Instance B: narrow counters, no drain latency
  logic        b_nrst, b_en, b_clr, b_query_valid, b_query_last;
  logic [4:0]  b_query_label, b_class_inference;
  logic        b_query_ready, b_start_querying, b_tdf;
  logic        b_result_valid, b_result_correct, b_busy, b_done;
  logic [4:0]  b_result_class;
  logic [1:0]  b_correct_count, b_total_count;

  am_query_sched #(.SEQ_CYCLE_COUNT(3), .AM_RESULT_LAT(0), .CNT_W(2)) dut_b (
    .clk(clk), .nrst(b_nrst), .en(b_en), .clr(b_clr),
    .query_valid(b_query_valid), .query_ready(b_query_ready),
    .query_label(b_query_label), .query_last(b_query_last),
    .start_querying(b_start_querying), .testing_dataset_finished(b_tdf),
    .class_inference(b_class_inference),
    .result_valid(b_result_valid), .result_class(b_result_class), .result_correct(b_result_correct),
    .correct_count(b_correct_count), .total_count(b_total_count),
    .busy(b_busy), .done(b_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] label;
    logic [4:0] cls;
    logic       last;
    int         stall_len;
    logic       clr_mid;
    logic       clr_hs;
    logic       exp_ok;
    int         exp_tot;
    int         exp_cor;
  } vec_t;

  // One query on instance A: handshake, walk every cycle to REPORT, then check
  // the cycle after REPORT. The correct class is presented only in the cycle
  // before REPORT; a decoy is presented otherwise.
  task automatic run_vec(input vec_t v);
    int guard;
    int rep;
    guard = 0;
    while (!query_ready && guard < 40) begin
      step();
      guard++;
    end
    chk("ready_before_hs", query_ready, 1);
    query_valid     = 1'b1;
    query_label     = v.label;
    query_last      = v.last;
    clr             = v.clr_hs;
    class_inference = ~v.cls;
    rep = 2 + SEQ + LAT + v.stall_len;
    for (int k = 1; k <= rep; k++) begin
      step();
      en              = !(v.stall_len != 0 && k >= 5 && k < 5 + v.stall_len);
      clr             = v.clr_mid && (k == 6);
      class_inference = (k == rep - 1) ? v.cls : ~v.cls;
      if (k == rep) query_valid = 1'b0;
      #1;
      chk("start_querying", start_querying, (k == 1));
      chk("result_valid", result_valid, (k == rep));
      chk("busy", busy, 1);
      chk("query_ready_busy", query_ready, 0);
      chk("done_in_query", done, 0);
      chk("tdf_in_query", testing_dataset_finished, 0);
      if (k == rep) begin
        chk("result_class", result_class, v.cls);
        chk("result_correct", result_correct, v.exp_ok);
        chk("total_count", total_count, v.exp_tot);
        chk("correct_count", correct_count, v.exp_cor);
      end
    end
    step();
    if (v.last) begin
      chk("done_pulse", done, 1);
      chk("tdf_pulse", testing_dataset_finished, 1);
      chk("busy_in_done", busy, 1);
    end else begin
      chk("busy_after", busy, 0);
      chk("ready_after", query_ready, 1);
      chk("done_nonlast", done, 0);
    end
  endtask

  vec_t vecs [7];
  vec_t extra;
  logic seen_rv;
  int   guard;

  initial begin
    vecs[0] = '{5'd7,  5'd7,  1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[1] = '{5'd3,  5'd5,  1'b0, 0, 1'b0, 1'b0, 1'b0, 2, 1};
    vecs[2] = '{5'd25, 5'd25, 1'b0, 5, 1'b0, 1'b0, 1'b1, 3, 2};
    vecs[3] = '{5'd0,  5'd0,  1'b0, 0, 1'b1, 1'b0, 1'b1, 4, 3};
    vecs[4] = '{5'd12, 5'd13, 1'b1, 0, 1'b0, 1'b0, 1'b0, 5, 3};
    vecs[5] = '{5'd9,  5'd9,  1'b0, 0, 1'b0, 1'b1, 1'b1, 1, 1};
    vecs[6] = '{5'd1,  5'd1,  1'b1, 0, 1'b0, 1'b0, 1'b1, 2, 2};
    extra   = '{5'd5,  5'd5,  1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 1};

    nrst = 1'b0; en = 1'b1; clr = 1'b0; query_valid = 1'b0;
    query_label = '0; query_last = 1'b0; class_inference = '0;
    b_nrst = 1'b0; b_en = 1'b1; b_clr = 1'b0; b_query_valid = 1'b0;
    b_query_label = '0; b_query_last = 1'b0; b_class_inference = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_total", total_count, 0);
    chk("rst_correct", correct_count, 0);
    chk("rst_class", result_class, 0);
    chk("rst_ok", result_correct, 0);
    nrst = 1'b1;
    b_nrst = 1'b1;
    step();
    chk("idle_ready", query_ready, 1);

    // en=0 in IDLE: offered query is not accepted
    en = 1'b0;
    query_valid = 1'b1;
    #1;
    chk("ready_en0", query_ready, 0);
    step();
    step();
    chk("busy_en0", busy, 0);
    query_valid = 1'b0;
    en = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset during the first DRAIN cycle aborts the query
    guard = 0;
    while (!query_ready && guard < 40) begin
      step();
      guard++;
    end
    chk("ready_before_rst_q", query_ready, 1);
    query_valid = 1'b1; query_label = 5'd4; query_last = 1'b0; class_inference = 5'd4;
    for (int k = 1; k <= 12; k++) begin
      step();
      query_valid = 1'b0;
    end
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_total", total_count, 0);
    chk("abort_correct", correct_count, 0);
    chk("abort_class", result_class, 0);
    seen_rv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (result_valid) seen_rv = 1'b1;
    end
    chk("abort_no_rv_later", seen_rv, 0);

    // New query, then clr in IDLE
    run_vec(extra);
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    chk("clr_idle_total", total_count, 0);
    chk("clr_idle_correct", correct_count, 0);

    // Instance B: 2-bit tallies saturate, no DRAIN phase
    for (int n = 1; n <= 5; n++) begin
      guard = 0;
      while (!b_query_ready && guard < 20) begin
        step();
        guard++;
      end
      chk("b_ready", b_query_ready, 1);
      b_query_valid = 1'b1;
      b_query_label = 5'(n);
      b_class_inference = ~5'(n);
      for (int k = 1; k <= 5; k++) begin
        step();
        b_class_inference = (k == 4) ? 5'(n) : ~5'(n);
        if (k == 5) b_query_valid = 1'b0;
        #1;
        chk("b_start", b_start_querying, (k == 1));
        chk("b_result_valid", b_result_valid, (k == 5));
        if (k == 5) begin
          chk("b_class", b_result_class, n);
          chk("b_ok", b_result_correct, 1);
          chk("b_total", b_total_count, (n > 3) ? 3 : n);
          chk("b_correct", b_correct_count, (n > 3) ? 3 : n);
        end
      end
      step();
      chk("b_idle_after", b_busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
